// File: rtl/nibble_demux_collector.sv
// Sequential 1-to-4 nibble demultiplexer: steers 4-bit slices into four lanes by a wrapping
// pointer and holds the assembled 16-bit word until the consumer takes it.
`timescale 1ns/1ns
module nibble_demux_collector (
   input  logic        Clk,
   input  logic        ResetN,
   input  logic        Flush,
   input  logic        InValid,
   input  logic [3:0]  InNibble,
   output logic        InReady,
   output logic [1:0]  Sel,
   output logic [3:0]  O0,
   output logic [3:0]  O1,
   output logic [3:0]  O2,
   output logic [3:0]  O3,
   output logic [15:0] Word,
   output logic        WordValid,
   input  logic        OutReady
);

   typedef enum logic [0:0] {StFill, StHold} state_e;

   state_e     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] lane_en;
   logic [3:0] lane_q [4];

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      lane_en = 4'b0000;
      unique case (state_q)
         StFill: begin
            if (InValid) begin
               unique case (sel_q)
                  2'd0: lane_en = 4'b0001;
                  2'd1: lane_en = 4'b0010;
                  2'd2: lane_en = 4'b0100;
                  2'd3: lane_en = 4'b1000;
                  default: lane_en = 4'b0000;
               endcase
               sel_d = sel_q + 2'd1;
               if (sel_q == 2'd3) begin
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            // Pointer already wrapped to 0 on the last slice; only the handshake matters here.
            if (OutReady) begin
               state_d = StFill;
            end
         end
         default: state_d = StFill;
      endcase
   end

   // Reset and Flush share the same clear; reset simply wins by being listed first.
   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         state_q <= StFill;
         sel_q   <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            lane_q[i] <= 4'h0;
         end
      end else if (Flush) begin
         state_q <= StFill;
         sel_q   <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            lane_q[i] <= 4'h0;
         end
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               lane_q[i] <= InNibble;
            end
         end
      end
   end

   assign InReady   = (state_q == StFill);
   assign WordValid = (state_q == StHold);
   assign Sel       = sel_q;
   assign O0        = lane_q[0];
   assign O1        = lane_q[1];
   assign O2        = lane_q[2];
   assign O3        = lane_q[3];
   assign Word      = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};

endmodule

// File: tb/tb_nibble_demux_collector.sv
// Bench for nibble_demux_collector: directed scenarios plus random traffic checked against a
// count-of-slices reference model.
`timescale 1ns/1ns
module tb_nibble_demux_collector;

   logic        Clk = 1'b0;
   logic        ResetN = 1'b0;
   logic        Flush = 1'b0;
   logic        InValid = 1'b0;
   logic [3:0]  InNibble = 4'h0;
   logic        InReady;
   logic [1:0]  Sel;
   logic [3:0]  O0, O1, O2, O3;
   logic [15:0] Word;
   logic        WordValid;
   logic        OutReady = 1'b0;

   int total = 0;
   int bad = 0;

   // Reference: slices collected so far for the current word (4 means the word is held).
   logic [3:0] m_lane [4];
   int         m_cnt = 0;

   always #5 Clk = ~Clk;

   nibble_demux_collector dut (
      .Clk      (Clk),
      .ResetN   (ResetN),
      .Flush    (Flush),
      .InValid  (InValid),
      .InNibble (InNibble),
      .InReady  (InReady),
      .Sel      (Sel),
      .O0       (O0),
      .O1       (O1),
      .O2       (O2),
      .O3       (O3),
      .Word     (Word),
      .WordValid(WordValid),
      .OutReady (OutReady)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge, update the model from the inputs that edge saw, compare every output.
   task automatic tick();
      @(posedge Clk);
      #1;
      if (!ResetN || Flush) begin
         for (int i = 0; i < 4; i++) m_lane[i] = 4'h0;
         m_cnt = 0;
      end else if (m_cnt < 4 && InValid) begin
         m_lane[m_cnt] = InNibble;
         m_cnt++;
      end else if (m_cnt == 4 && OutReady) begin
         m_cnt = 0;
      end
      chk("sel", 16'(Sel), 16'(m_cnt % 4));
      chk("in_ready", 16'(InReady), 16'(m_cnt < 4));
      chk("word_valid", 16'(WordValid), 16'(m_cnt == 4));
      chk("o0", 16'(O0), 16'(m_lane[0]));
      chk("o1", 16'(O1), 16'(m_lane[1]));
      chk("o2", 16'(O2), 16'(m_lane[2]));
      chk("o3", 16'(O3), 16'(m_lane[3]));
      chk("word", Word, {m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
   endtask

   task automatic slice(input logic [3:0] n);
      InValid  = 1'b1;
      InNibble = n;
      tick();
      InValid  = 1'b0;
   endtask

   initial begin
      int pulses;
      int pulse_at [2];
      logic [15:0] pulse_word [2];
      int idx;

      for (int i = 0; i < 4; i++) m_lane[i] = 4'h0;

      // Reset with a slice presented: it must be dropped.
      ResetN = 1'b0; InValid = 1'b1; InNibble = 4'hF;
      tick(); tick();
      chk("rst_word", Word, 16'h0000);
      chk("rst_sel", 16'(Sel), 16'd0);
      chk("rst_in_ready", 16'(InReady), 16'd1);
      chk("rst_word_valid", 16'(WordValid), 16'd0);
      ResetN = 1'b1; InValid = 1'b0;

      // Basic fill with consumer stalled.
      OutReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("fill_sel_pre", 16'(Sel), 16'(i));
         slice(4'(i + 1));
      end
      chk("fill_sel_wrap", 16'(Sel), 16'd0);
      chk("fill_word", Word, 16'h4321);
      chk("fill_wv", 16'(WordValid), 16'd1);
      InValid = 1'b1; InNibble = 4'hA;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_word", Word, 16'h4321);
         chk("hold_in_ready", 16'(InReady), 16'd0);
      end

      // Back-to-back words with the consumer always ready.
      OutReady = 1'b1;
      pulses = 0;
      idx = 0;
      for (int c = 1; c <= 14; c++) begin
         InValid  = (idx < 8);
         InNibble = 4'(idx + 1);
         if (m_cnt < 4 && InValid) idx++;
         tick();
         if (WordValid) begin
            if (pulses < 2) begin
               pulse_at[pulses] = c;
               pulse_word[pulses] = Word;
            end
            pulses++;
         end
      end
      InValid = 1'b0;
      chk("b2b_pulses", 16'(pulses), 16'd2);
      chk("b2b_word0", pulse_word[0], 16'h4321);
      chk("b2b_word1", pulse_word[1], 16'h8765);
      chk("b2b_period", 16'(pulse_at[1] - pulse_at[0]), 16'd5);

      // Gapped input.
      OutReady = 1'b0;
      slice(4'hC);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("gap_sel1", 16'(Sel), 16'd1);
      end
      slice(4'hD);
      tick();
      chk("gap_sel2", 16'(Sel), 16'd2);
      slice(4'hE);
      slice(4'hF);
      chk("gap_word", Word, 16'hFEDC);
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;

      // Flush mid-fill with a colliding slice.
      slice(4'h9);
      slice(4'h8);
      Flush = 1'b1;
      slice(4'h7);
      Flush = 1'b0;
      chk("flush_word", Word, 16'h0000);
      chk("flush_sel", 16'(Sel), 16'd0);
      for (int i = 0; i < 4; i++) slice(4'(i + 1));
      chk("post_flush_word", Word, 16'h4321);

      // Flush while holding.
      chk("pre_flush_wv", 16'(WordValid), 16'd1);
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      chk("hflush_wv", 16'(WordValid), 16'd0);
      chk("hflush_word", Word, 16'h0000);
      chk("hflush_in_ready", 16'(InReady), 16'd1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         ResetN   = ($urandom_range(0, 49) != 0);
         Flush    = ($urandom_range(0, 29) == 0);
         InValid  = ($urandom_range(0, 3) != 0);
         InNibble = 4'($urandom);
         OutReady = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
